// File: rtl/spart_rx.sv
// spart_rx: receive half of the SPART.
// Samples rxd with a 16x (OVERSAMPLE) baud tick, deserialises 8N1 frames
// LSB first, and holds the last byte in a one-entry buffer that the
// processor reads over the iocs/iorw/ioaddr bus (address 2'b00).
// Optional build macro SPART_RX_PARITY_EN: frames become 8E1, an even
// parity bit is sampled after the data bits and reported on parity_err.
// Without the macro parity_err is tied low.
module spart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rxd,
    input  logic                 iocs,
    input  logic                 iorw,
    input  logic [1:0]           ioaddr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 parity_err
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] MID   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

`ifdef SPART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rxs;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rda_q, rda_d;
    logic                   fe_q, fe_d;
    logic                   rd_hit;
`ifdef SPART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   pe_q, pe_d;
`endif

    assign rxs    = sync_q[1];
    assign rd_hit = iocs & iorw & (ioaddr == 2'b00);

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rxd};
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rda_q     <= 1'b0;
            fe_q      <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            par_q     <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            fe_q      <= fe_d;
`ifdef SPART_RX_PARITY_EN
            par_q     <= par_d;
            pe_q      <= pe_d;
`endif
        end
    end

    // Next state: everything advances on the oversample tick; a bus read
    // clears rda, but a frame completing in the same cycle takes priority.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        fe_d      = fe_q;
`ifdef SPART_RX_PARITY_EN
        par_d     = par_q;
        pe_d      = pe_q;
`endif
        if (rd_hit) rda_d = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == MID) begin
                        // Line must still be low mid start bit, else a glitch.
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == LAST) begin
                        tick_d  = '0;
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BLAST) begin
`ifdef SPART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`ifdef SPART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == LAST) begin
                        tick_d  = '0;
                        par_d   = rxs;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_q == LAST) begin
                        // Deliver even with a bad stop bit; overrun overwrites.
                        tick_d    = '0;
                        rx_data_d = shift_q;
                        rda_d     = 1'b1;
                        fe_d      = ~rxs;
`ifdef SPART_RX_PARITY_EN
                        pe_d      = (^shift_q) ^ par_q;
`endif
                        state_d   = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign framing_err = fe_q;
`ifdef SPART_RX_PARITY_EN
    assign parity_err  = pe_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: frames are driven bit-serially, the
// expected byte/flags are queued when a frame starts and popped by a
// monitor when the receiver delivers a byte.
module tb_spart_rx;
`ifdef SPART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 11 : 10;
    // Clock (relative to start-bit drive) on whose edge the frame completes.
    localparam int COMP  = PAR ? 170 : 154;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, enable, rxd, iocs, iorw;
    logic [1:0] ioaddr;
    logic [7:0] rx_data;
    logic       rda, framing_err, parity_err;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         div = 1;
    logic       rda_at_rd;
    logic       prev_rda = 1'b0;
    logic [7:0] prev_data = 8'h00;

    spart_rx dut (
        .clk(clk), .rst(rst), .enable(enable), .rxd(rxd),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .rx_data(rx_data), .rda(rda),
        .framing_err(framing_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Monitor: a byte is delivered when rda rises or the buffer changes under rda.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_rda  = 1'b0;
            prev_data = 8'h00;
        end else begin
            if (rda && (!prev_rda || rx_data != prev_data)) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_byte: got %02h, none expected", rx_data);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (rx_data !== e.data) begin
                        n_bad++;
                        $display("FAIL rx_data: got %02h, expected %02h", rx_data, e.data);
                    end
                    n_cmp++;
                    if (framing_err !== e.fe) begin
                        n_bad++;
                        $display("FAIL framing_err(%02h): got %b, expected %b", e.data, framing_err, e.fe);
                    end
                    n_cmp++;
                    if (parity_err !== e.pe) begin
                        n_bad++;
                        $display("FAIL parity_err(%02h): got %b, expected %b", e.data, parity_err, e.pe);
                    end
                end
            end
            prev_rda  = rda;
            prev_data = rx_data;
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
        enable = (div <= 1) ? 1'b1 : ((cyc % div) == 0);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic pflip, input int rd_at);
        logic [10:0] fr;
        exp_t        e;
        fr      = '1;
        fr[0]   = 1'b0;
        fr[8:1] = d;
        if (PAR) begin
            fr[9]  = (^d) ^ pflip;
            fr[10] = stop;
        end else begin
            fr[9]  = stop;
        end
        e.data = d;
        e.fe   = ~stop;
        e.pe   = PAR ? pflip : 1'b0;
        sb.push_back(e);
        for (int c = 0; c < NBITS * 16 * div; c++) begin
            if (c == rd_at + 1) rda_at_rd = rda;
            rxd = fr[c / (16 * div)];
            if (c == rd_at) begin
                iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
            end else begin
                iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
            end
            step();
        end
        rxd = 1'b1; iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic read_pulse(input logic [1:0] a, input logic rw);
        iocs = 1'b1; iorw = rw; ioaddr = a;
        step();
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        step();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_delivery: %0d frame(s) never delivered, expected 0 pending", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; enable = 1'b0;
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        repeat (3) step();
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %02h, expected 00", rx_data); end
        n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL reset_rda: got %b, expected 0", rda); end
        n_cmp++; if (framing_err !== 1'b0) begin n_bad++; $display("FAIL reset_framing_err: got %b, expected 0", framing_err); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_parity_err: got %b, expected 0", parity_err); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(8);
        wait_drain("basic");
    endtask

    task automatic test_read();
        read_pulse(2'b01, 1'b1);
        n_cmp++; if (rda !== 1'b1) begin n_bad++; $display("FAIL read_other_addr_rda: got %b, expected 1", rda); end
        read_pulse(2'b00, 1'b0);
        n_cmp++; if (rda !== 1'b1) begin n_bad++; $display("FAIL write_rda: got %b, expected 1", rda); end
        read_pulse(2'b00, 1'b1);
        n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL read_clear_rda: got %b, expected 0", rda); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL read_hold_data: got %02h, expected a5", rx_data); end
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (5) step();
        idle(200);
        n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL glitch_rda: got %b, expected 0", rda); end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        idle(40);
        wait_drain("framing_bad");
        read_pulse(2'b00, 1'b1);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        idle(8);
        wait_drain("framing_good");
    endtask

    task automatic test_back_to_back();
        read_pulse(2'b00, 1'b1);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, COMP);
        n_cmp++; if (rda_at_rd !== 1'b1) begin n_bad++; $display("FAIL collision_rda: got %b, expected 1", rda_at_rd); end
        idle(8);
        wait_drain("overrun");
        n_cmp++; if (rda !== 1'b1) begin n_bad++; $display("FAIL overrun_rda: got %b, expected 1", rda); end
        n_cmp++; if (rx_data !== 8'h22) begin n_bad++; $display("FAIL overrun_data: got %02h, expected 22", rx_data); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'hF0;
        rxd = 1'b0;
        repeat (16) step();
        for (int b = 0; b < 4; b++) begin
            rxd = d[b];
            repeat (16) step();
        end
        rst = 1'b1; rxd = 1'b1;
        #1;
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL midreset_rx_data: got %02h, expected 00", rx_data); end
        n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL midreset_rda: got %b, expected 0", rda); end
        n_cmp++; if (framing_err !== 1'b0) begin n_bad++; $display("FAIL midreset_framing_err: got %b, expected 0", framing_err); end
        step();
        rst = 1'b0;
        idle(200);
        n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL midreset_no_byte: got rda %b, expected 0", rda); end
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        idle(8);
        wait_drain("after_reset");
    endtask

    task automatic test_slow_enable();
        read_pulse(2'b00, 1'b1);
        div = 4;
        idle(8);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        idle(32);
        wait_drain("slow");
        div = 1;
        idle(4);
        n_cmp++; if (rx_data !== 8'h5A) begin n_bad++; $display("FAIL slow_data: got %02h, expected 5a", rx_data); end
    endtask

    task automatic test_parity();
        read_pulse(2'b00, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(8);
        wait_drain("parity_ok");
        read_pulse(2'b00, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(8);
        wait_drain("parity_bad");
        n_cmp++; if (rda !== 1'b1) begin n_bad++; $display("FAIL parity_rda: got %b, expected 1", rda); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_read();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
        test_slow_enable();
        test_parity();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
